// File: rtl/uid_pkg.sv
// Shared types for the UID matcher: FSM state encoding, guest index, attempt counter
// width and the all-ones sentinel helper.
package uid_pkg;

  typedef enum logic [2:0] {
    ENTRY,
    FETCH,
    WAIT,
    CATCH,
    COMPARE,
    MATCHED,
    LOCKED
  } state_e;

  localparam int GUEST_IDX  = 0;
  localparam int ATTEMPT_W  = 3;
  localparam int SENT_MAX_W = 64;

  // End-of-table marker: w low bits set; callers cast down to their ID width.
  function automatic logic [SENT_MAX_W-1:0] sentinel(input int w);
    logic [SENT_MAX_W-1:0] m;
    m = '0;
    for (int i = 0; i < SENT_MAX_W; i++) begin
      if (i < w) m[i] = 1'b1;
    end
    return m;
  endfunction

endpackage

// File: rtl/uid_matcher_lockout_timer.sv
// Lockout down-counter for uid_matcher; exists only when ID_LOCKOUT_EN is defined.
// done_o pulses in the LOCK_CYCLES-th cycle after start_i.
`ifdef ID_LOCKOUT_EN
module lockout_timer #(
  parameter int LOCK_CYCLES = 50_000_000
) (
  input  logic clk,
  input  logic rst,
  input  logic start_i,
  output logic done_o
);
  localparam int CNT_W = (LOCK_CYCLES > 1) ? $clog2(LOCK_CYCLES + 1) : 1;

  logic [CNT_W-1:0] cnt_q;
  logic             active_q;

  assign done_o = active_q && (cnt_q == '0);

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_q    <= '0;
      active_q <= 1'b0;
    end else if (start_i) begin
      cnt_q    <= CNT_W'(LOCK_CYCLES - 1);
      active_q <= 1'b1;
    end else if (active_q) begin
      if (cnt_q == '0) active_q <= 1'b0;
      else             cnt_q    <= cnt_q - 1'b1;
    end
  end
endmodule
`endif

// File: rtl/uid_matcher.sv
// uid_matcher: collects NUM_DIGITS digits, scans the UID ROM up to the all-ones sentinel and
// reports match/index/guest. Failed-attempt lockout is built only when ID_LOCKOUT_EN is defined.
module uid_matcher
  import uid_pkg::*;
#(
  parameter int NUM_DIGITS   = 4,
  parameter int DIGIT_W      = 4,
  parameter int ADDR_W       = 5,
  parameter int ROM_LAT      = 2,
  parameter int MAX_ATTEMPTS = 3,
  parameter int LOCK_CYCLES  = 50_000_000,
  localparam int ID_W        = NUM_DIGITS * DIGIT_W
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [DIGIT_W-1:0]   pwdigit,
  input  logic                 pwenter,
  input  logic                 log_out,
  input  logic [ID_W-1:0]      q_UID_ROM,
  output logic [ADDR_W-1:0]    addr_UID_ROM,
  output logic                 matchID,
  output logic                 isGuest,
  output logic [ADDR_W-1:0]    intID,
  output logic                 fail,
  output logic [ATTEMPT_W-1:0] attempts,
  output logic                 busy,
  output logic                 locked
);
  localparam int CNT_W  = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;
  localparam int WAIT_W = (ROM_LAT > 1) ? $clog2(ROM_LAT) : 1;
  localparam logic [ID_W-1:0] SENTINEL = ID_W'(sentinel(ID_W));

  if (ROM_LAT < 1 || MAX_ATTEMPTS < 1 || LOCK_CYCLES < 1 || ID_W > SENT_MAX_W) begin : g_bad_cfg
    $error("uid_matcher: invalid parameter set");
  end

  state_e                 state_q;
  logic [ID_W-1:0]        uid_q, uid_d, data_q;
  logic [CNT_W-1:0]       cnt_q;
  logic [WAIT_W-1:0]      wait_q;
  logic [ADDR_W-1:0]      index_q, addr_q, int_id_q;
  logic                   match_q, guest_q, fail_q, busy_q;
  logic [ATTEMPT_W-1:0]   attempts_q, attempts_d;
  logic                   is_sent, is_hit, scan_fail, scanning;

  if (NUM_DIGITS > 1) begin : g_shift
    assign uid_d = {uid_q[ID_W-DIGIT_W-1:0], pwdigit};
  end else begin : g_single
    assign uid_d = pwdigit;
  end

  // The sentinel wins over an equal UID, so an all-ones ID can never match.
  assign is_sent    = (data_q == SENTINEL);
  assign is_hit     = (data_q == uid_q);
  assign scan_fail  = is_sent || (!is_hit && (index_q == '1));
  assign attempts_d = (attempts_q == '1) ? attempts_q : attempts_q + 1'b1;
  assign scanning   = (state_q == FETCH) || (state_q == WAIT) ||
                      (state_q == CATCH) || (state_q == COMPARE);

`ifdef ID_LOCKOUT_EN
  logic locked_q, lock_hit, lock_start, lock_done;
  assign lock_hit   = (attempts_d == ATTEMPT_W'(MAX_ATTEMPTS));
  assign lock_start = (state_q == COMPARE) && !log_out && scan_fail && lock_hit;
  lockout_timer #(.LOCK_CYCLES(LOCK_CYCLES)) u_lockout_timer (
    .clk     (clk),
    .rst     (rst),
    .start_i (lock_start),
    .done_o  (lock_done)
  );
  assign locked = locked_q;
`else
  assign locked = 1'b0;
`endif

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= ENTRY;
      uid_q      <= '0;
      data_q     <= '0;
      cnt_q      <= '0;
      wait_q     <= '0;
      index_q    <= '0;
      addr_q     <= '0;
      int_id_q   <= '0;
      match_q    <= 1'b0;
      guest_q    <= 1'b0;
      fail_q     <= 1'b0;
      busy_q     <= 1'b0;
      attempts_q <= '0;
`ifdef ID_LOCKOUT_EN
      locked_q   <= 1'b0;
`endif
    end else begin
      fail_q <= 1'b0;
      if (scanning && log_out) begin
        uid_q   <= '0;
        cnt_q   <= '0;
        busy_q  <= 1'b0;
        state_q <= ENTRY;
      end else begin
        case (state_q)
          ENTRY: begin
            if (log_out) begin
              uid_q <= '0;
              cnt_q <= '0;
            end else if (pwenter) begin
              uid_q <= uid_d;
              if (cnt_q == CNT_W'(NUM_DIGITS - 1)) begin
                cnt_q   <= '0;
                index_q <= '0;
                busy_q  <= 1'b1;
                state_q <= FETCH;
              end else begin
                cnt_q <= cnt_q + 1'b1;
              end
            end
          end
          FETCH: begin
            addr_q  <= index_q;
            wait_q  <= '0;
            state_q <= WAIT;
          end
          WAIT: begin
            if (wait_q == WAIT_W'(ROM_LAT - 1)) state_q <= CATCH;
            else                                wait_q  <= wait_q + 1'b1;
          end
          CATCH: begin
            data_q  <= q_UID_ROM;
            state_q <= COMPARE;
          end
          COMPARE: begin
            if (scan_fail) begin
              fail_q     <= 1'b1;
              attempts_q <= attempts_d;
              uid_q      <= '0;
              cnt_q      <= '0;
              busy_q     <= 1'b0;
`ifdef ID_LOCKOUT_EN
              locked_q   <= lock_hit;
              state_q    <= lock_hit ? LOCKED : ENTRY;
`else
              state_q    <= ENTRY;
`endif
            end else if (is_hit) begin
              match_q    <= 1'b1;
              int_id_q   <= index_q;
              guest_q    <= (index_q == ADDR_W'(GUEST_IDX));
              attempts_q <= '0;
              busy_q     <= 1'b0;
              state_q    <= MATCHED;
            end else begin
              index_q <= index_q + 1'b1;
              state_q <= FETCH;
            end
          end
          MATCHED: begin
            if (log_out) begin
              match_q  <= 1'b0;
              guest_q  <= 1'b0;
              int_id_q <= '0;
              addr_q   <= '0;
              uid_q    <= '0;
              cnt_q    <= '0;
              state_q  <= ENTRY;
            end
          end
`ifdef ID_LOCKOUT_EN
          LOCKED: begin
            if (lock_done) begin
              locked_q   <= 1'b0;
              attempts_q <= '0;
              state_q    <= ENTRY;
            end
          end
`endif
          default: state_q <= ENTRY;
        endcase
      end
    end
  end

  assign addr_UID_ROM = addr_q;
  assign matchID      = match_q;
  assign isGuest      = guest_q;
  assign intID        = int_id_q;
  assign fail         = fail_q;
  assign attempts     = attempts_q;
  assign busy         = busy_q;
endmodule

// File: tb/tb_uid_matcher.sv
// Bench for uid_matcher: ROM_LAT=2 and ROM_LAT=4 instances share stimulus; table-driven
// lookups with a scoreboard queue plus hand-written abort/reset/lockout sequences.
module tb_uid_matcher;
  localparam int AW = 5;
  localparam int IW = 16;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic pwenter = 1'b0;
  logic log_out = 1'b0;
  logic [3:0] pwdigit = 4'h0;

  always #5 clk = ~clk;

  logic [IW-1:0] q2, q4;
  logic [AW-1:0] addr2, addr4, id2, id4;
  logic m2, m4, g2, g4, f2, f4, b2, b4, l2, l4;
  logic [2:0] a2, a4;

  uid_matcher #(.ROM_LAT(2), .LOCK_CYCLES(20)) dut2 (
    .clk(clk), .rst(rst), .pwdigit(pwdigit), .pwenter(pwenter), .log_out(log_out),
    .q_UID_ROM(q2), .addr_UID_ROM(addr2), .matchID(m2), .isGuest(g2), .intID(id2),
    .fail(f2), .attempts(a2), .busy(b2), .locked(l2));

  uid_matcher #(.ROM_LAT(4), .LOCK_CYCLES(20)) dut4 (
    .clk(clk), .rst(rst), .pwdigit(pwdigit), .pwenter(pwenter), .log_out(log_out),
    .q_UID_ROM(q4), .addr_UID_ROM(addr4), .matchID(m4), .isGuest(g4), .intID(id4),
    .fail(f4), .attempts(a4), .busy(b4), .locked(l4));

  // ROM model with exactly ROM_LAT register stages between address and data
  logic [IW-1:0] rom [32];
  logic [IW-1:0] p2 [2];
  logic [IW-1:0] p4 [4];
  initial begin
    for (int i = 0; i < 32; i++) rom[i] = 16'hFFFF;
    rom[0] = 16'h0000;
    rom[1] = 16'h9989;
    rom[2] = 16'h1234;
  end
  always @(posedge clk) begin
    p2[0] <= rom[addr2];
    p2[1] <= p2[0];
    p4[0] <= rom[addr4];
    for (int i = 1; i < 4; i++) p4[i] <= p4[i-1];
  end
  assign q2 = p2[1];
  assign q4 = p4[3];

  int lkc2 = 0;
  int lkc4 = 0;
  always @(posedge clk) begin
    if (l2) lkc2 <= lkc2 + 1;
    if (l4) lkc4 <= lkc4 + 1;
  end

  int checks = 0;
  int errors = 0;

  typedef struct { bit m; int k; int att; bit lk; } exp_t;
  exp_t exp_q[$];

  typedef struct { logic [15:0] id; bit m; int k; int att; } vec_t;
  vec_t tbl[6];

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0d required=%0d", nm, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk_idle(input string tag);
    chk({tag, "_match2"}, 32'(m2), 0);   chk({tag, "_match4"}, 32'(m4), 0);
    chk({tag, "_guest2"}, 32'(g2), 0);   chk({tag, "_guest4"}, 32'(g4), 0);
    chk({tag, "_intid2"}, 32'(id2), 0);  chk({tag, "_intid4"}, 32'(id4), 0);
    chk({tag, "_fail2"}, 32'(f2), 0);    chk({tag, "_fail4"}, 32'(f4), 0);
    chk({tag, "_busy2"}, 32'(b2), 0);    chk({tag, "_busy4"}, 32'(b4), 0);
    chk({tag, "_locked2"}, 32'(l2), 0);  chk({tag, "_locked4"}, 32'(l4), 0);
    chk({tag, "_addr2"}, 32'(addr2), 0); chk({tag, "_addr4"}, 32'(addr4), 0);
  endtask

  task automatic enter_digits(input logic [15:0] id);
    for (int i = 3; i >= 0; i--) begin
      pwdigit = id[i*4 +: 4];
      pwenter = 1'b1;
      tick();
      pwenter = 1'b0;
    end
  endtask

  // One ID lookup; result is compared against the queued expectation.
  task automatic lookup(input logic [15:0] id, input bit em, input int ek, input int eatt, input bit elk);
    exp_t e;
    int s2, s4;
    logic rm2, rm4, rg2, rg4, rb2, rb4, rl2, rl4, fn2, fn4;
    logic [AW-1:0] ri2, ri4;
    logic [2:0] ra2, ra4;
    e.m = em; e.k = ek; e.att = eatt; e.lk = elk;
    exp_q.push_back(e);
    enter_digits(id);
    chk("busy_start2", 32'(b2), 1);
    chk("busy_start4", 32'(b4), 1);
    s2 = -1; s4 = -1; fn2 = 1'b0;
    {rm2, rm4, rg2, rg4, rb2, rb4, rl2, rl4} = '0;
    ri2 = '0; ri4 = '0; ra2 = '0; ra4 = '0;
    for (int c = 1; c <= 80 && (s2 < 0 || s4 < 0); c++) begin
      tick();
      if (s2 >= 0 && c == s2 + 1) fn2 = f2;
      if (s2 < 0 && (m2 || f2)) begin
        s2 = c; rm2 = m2; rg2 = g2; ri2 = id2; ra2 = a2; rb2 = b2; rl2 = l2;
      end
      if (s4 < 0 && (m4 || f4)) begin
        s4 = c; rm4 = m4; rg4 = g4; ri4 = id4; ra4 = a4; rb4 = b4; rl4 = l4;
      end
    end
    tick();
    fn4 = f4;
    e = exp_q.pop_front();
    chk("latency2", 32'(s2), 32'((e.k + 1) * 5));
    chk("latency4", 32'(s4), 32'((e.k + 1) * 7));
    chk("match2", 32'(rm2), 32'(e.m));
    chk("match4", 32'(rm4), 32'(e.m));
    chk("attempts2", 32'(ra2), 32'(e.att));
    chk("attempts4", 32'(ra4), 32'(e.att));
    chk("busy_done2", 32'(rb2), 0);
    chk("busy_done4", 32'(rb4), 0);
    chk("locked2", 32'(rl2), 32'(e.lk));
    chk("locked4", 32'(rl4), 32'(e.lk));
    chk("fail_pulse2", 32'(fn2), 0);
    chk("fail_pulse4", 32'(fn4), 0);
    if (e.m) begin
      chk("intid2", 32'(ri2), 32'(e.k));
      chk("intid4", 32'(ri4), 32'(e.k));
      chk("guest2", 32'(rg2), 32'(e.k == 0));
      chk("guest4", 32'(rg4), 32'(e.k == 0));
      log_out = 1'b1;
      tick();
      log_out = 1'b0;
      chk_idle("logout");
      chk("logout_att2", 32'(a2), 0);
      chk("logout_att4", 32'(a4), 0);
    end
    $display("lookup id=%h lat2=%0d lat4=%0d match=%0d idx=%0d att=%0d locked=%0d",
             id, s2, s4, rm2, ri2, ra2, rl2);
  endtask

  initial begin
    int att_snap, cnt, base2, base4;
    tbl[0] = '{16'h9989, 1'b1, 1, 0};
    tbl[1] = '{16'h0000, 1'b1, 0, 0};
    tbl[2] = '{16'h1234, 1'b1, 2, 0};
    tbl[3] = '{16'h5555, 1'b0, 3, 1};
    tbl[4] = '{16'hFFFF, 1'b0, 3, 2};
    tbl[5] = '{16'h9989, 1'b1, 1, 0};

    tick();
    tick();
    chk_idle("reset");
    chk("reset_att2", 32'(a2), 0);
    chk("reset_att4", 32'(a4), 0);
    rst = 1'b0;
    tick();

    foreach (tbl[i]) lookup(tbl[i].id, tbl[i].m, tbl[i].k, tbl[i].att, 1'b0);

    // log_out during the scan aborts it without a fail pulse
    att_snap = int'(a2);
    enter_digits(16'h5555);
    tick(); tick(); tick();
    log_out = 1'b1;
    tick();
    log_out = 1'b0;
    chk("abort_busy2", 32'(b2), 0);
    chk("abort_busy4", 32'(b4), 0);
    cnt = 0;
    for (int c = 0; c < 40; c++) begin
      tick();
      if (f2 || f4 || m2 || m4) cnt++;
    end
    chk("abort_nofail", 32'(cnt), 0);
    chk("abort_att2", 32'(a2), 32'(att_snap));
    chk("abort_att4", 32'(a4), 32'(att_snap));
    $display("abort scan: events=%0d attempts=%0d", cnt, a2);

    // reset while waiting on the ROM
    enter_digits(16'h5555);
    tick();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    chk_idle("midrst");
    cnt = 0;
    for (int c = 0; c < 40; c++) begin
      tick();
      if (f2 || f4 || m2 || m4) cnt++;
    end
    chk("midrst_nofail", 32'(cnt), 0);
    $display("reset mid-scan: events=%0d", cnt);

    // log_out beats a simultaneous pwenter, and clears the partial entry
    for (int i = 0; i < 3; i++) begin
      pwdigit = (i == 2) ? 4'h8 : 4'h9;
      pwenter = 1'b1;
      tick();
    end
    pwdigit = 4'h9;
    log_out = 1'b1;
    tick();
    pwenter = 1'b0;
    log_out = 1'b0;
    chk("logout_pw_busy2", 32'(b2), 0);
    lookup(16'h0000, 1'b1, 0, 0, 1'b0);

`ifdef ID_LOCKOUT_EN
    lookup(16'h5555, 1'b0, 3, 1, 1'b0);
    lookup(16'h5555, 1'b0, 3, 2, 1'b0);
    base2 = lkc2;
    base4 = lkc4;
    lookup(16'h5555, 1'b0, 3, 3, 1'b1);
    for (int i = 0; i < 8; i++) begin
      pwdigit = 4'h0;
      pwenter = 1'b1;
      tick();
      chk("lock_pw_busy2", 32'(b2), 0);
    end
    pwenter = 1'b0;
    cnt = 0;
    while ((l2 || l4) && cnt < 60) begin
      tick();
      cnt++;
    end
    chk("unlock_timeout", 32'(cnt < 60), 1);
    tick();
    chk("lock_len2", 32'(lkc2 - base2), 20);
    chk("lock_len4", 32'(lkc4 - base4), 20);
    chk("unlock_att2", 32'(a2), 0);
    chk("unlock_att4", 32'(a4), 0);
    $display("lockout: len2=%0d len4=%0d", lkc2 - base2, lkc4 - base4);
    lookup(16'h0000, 1'b1, 0, 0, 1'b0);
`else
    base2 = lkc2;
    base4 = lkc4;
    for (int i = 0; i < 8; i++) lookup(16'h5555, 1'b0, 3, (i + 1 > 7) ? 7 : i + 1, 1'b0);
    chk("nolock_cnt2", 32'(lkc2 - base2), 0);
    chk("nolock_cnt4", 32'(lkc4 - base4), 0);
`endif

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
